wb_commit_multi: RTL and testbench

Parametrised multi-lane writeback/commit stage. It sits after the MEM stage and replaces the single-lane writeback for wide-issue pipeline configurations. It registers up to LANES completed instructions per cycle and resolves same-register and CSR write conflicts in program order. It also suppresses x0 writes, counts retired instructions and latches a halt condition that freezes commit until reset.

---
 rtl/wb_commit_multi.sv | 199 +++++++++++++++++++
 tb/tb_wb_commit_multi.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_multi.sv
// wb_commit_multi: multi-lane writeback/commit stage.
//
// Registers up to LANES completed instructions per cycle (lane 0 oldest).
// Conflicts between same-register and CSR writes are resolved in program
// order, so the youngest write wins. Writes to x0 are suppressed and retired
// instructions are counted. A retired halt instruction freezes commit until
// reset. Every output is registered, giving a latency of one cycle.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   in_valid[L]         lane holds a completed instruction
//   in_wr_reg[L]        lane writes the register file
//   in_wregno[L*R]      destination register, lane i at [i*R +: R]
//   in_regval[L*D]      register write data
//   in_wr_csr[L]        lane writes a CSR
//   in_wcsrno[L*C]      CSR index
//   in_csrval[L*D]      CSR write data
//   in_halt[L]          lane is a halt instruction
//   rf_we/waddr/wdata   per-lane register-file write port
//   csr_we/waddr/wdata  single CSR write port (youngest live CSR write)
//   csr_conflict        two or more live CSR writes were seen in one cycle
//   retire_count        instructions retired since reset (wraps)
//   retired[L]          per-lane retire mask
//   halted              a halt instruction has retired
//
// Optional build macro WB_TRACE_EN: adds a simulation-only trace array
// last_wb_value and a per-lane retire printout. The port list is unchanged.

module wb_commit_multi #(
  parameter int unsigned LANES     = 2,
  parameter int unsigned DBITS     = 32,
  parameter int unsigned REGNOBITS = 5,
  parameter int unsigned CSRNOBITS = 12,
  parameter int unsigned CNTBITS   = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [LANES-1:0]           in_valid,
  input  logic [LANES-1:0]           in_wr_reg,
  input  logic [LANES*REGNOBITS-1:0] in_wregno,
  input  logic [LANES*DBITS-1:0]     in_regval,
  input  logic [LANES-1:0]           in_wr_csr,
  input  logic [LANES*CSRNOBITS-1:0] in_wcsrno,
  input  logic [LANES*DBITS-1:0]     in_csrval,
  input  logic [LANES-1:0]           in_halt,
  output logic [LANES-1:0]           rf_we,
  output logic [LANES*REGNOBITS-1:0] rf_waddr,
  output logic [LANES*DBITS-1:0]     rf_wdata,
  output logic                       csr_we,
  output logic [CSRNOBITS-1:0]       csr_waddr,
  output logic [DBITS-1:0]           csr_wdata,
  output logic                       csr_conflict,
  output logic [CNTBITS-1:0]         retire_count,
  output logic [LANES-1:0]           retired,
  output logic                       halted
);

  localparam logic [0:0] StRun    = 1'b0;
  localparam logic [0:0] StHalted = 1'b1;

  logic [0:0]                 state_q, state_d;
  logic [LANES-1:0]           rf_we_q, rf_we_d;
  logic [LANES*REGNOBITS-1:0] rf_waddr_q, rf_waddr_d;
  logic [LANES*DBITS-1:0]     rf_wdata_q, rf_wdata_d;
  logic                       csr_we_q, csr_we_d;
  logic [CSRNOBITS-1:0]       csr_waddr_q, csr_waddr_d;
  logic [DBITS-1:0]           csr_wdata_q, csr_wdata_d;
  logic                       csr_conflict_q, csr_conflict_d;
  logic [CNTBITS-1:0]         retire_count_q, retire_count_d;
  logic [LANES-1:0]           retired_q, retired_d;

  logic [LANES-1:0] live;
  logic             older_halt;
  logic [LANES-1:0] csr_hit;
  logic [2:0]       live_cnt;
  logic [2:0]       csr_cnt;

  // A halt squashes every younger lane in the same cycle, but it still
  // retires itself.
  always_comb begin
    older_halt = 1'b0;
    live       = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      live[i]    = in_valid[i] & (state_q == StRun) & ~older_halt;
      older_halt = older_halt | (in_valid[i] & in_halt[i]);
    end
  end

  // Register writes: drop x0, and drop any write that a younger live lane
  // overwrites in the same cycle.
  always_comb begin
    rf_we_d = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      rf_we_d[i] = live[i] & in_wr_reg[i] &
                   (in_wregno[i*REGNOBITS +: REGNOBITS] != '0);
      for (int unsigned k = 0; k < LANES; k++) begin
        if ((k > i) && live[k] && in_wr_reg[k] &&
            (in_wregno[k*REGNOBITS +: REGNOBITS] == in_wregno[i*REGNOBITS +: REGNOBITS])) begin
          rf_we_d[i] = 1'b0;
        end
      end
    end
  end

  // CSR port: the ascending scan leaves the youngest live CSR write selected.
  always_comb begin
    csr_hit     = live & in_wr_csr;
    csr_we_d    = 1'b0;
    csr_waddr_d = csr_waddr_q;
    csr_wdata_d = csr_wdata_q;
    csr_cnt     = '0;
    live_cnt    = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (csr_hit[i]) begin
        csr_we_d    = 1'b1;
        csr_waddr_d = in_wcsrno[i*CSRNOBITS +: CSRNOBITS];
        csr_wdata_d = in_csrval[i*DBITS +: DBITS];
      end
      csr_cnt  = csr_cnt + {2'b00, csr_hit[i]};
      live_cnt = live_cnt + {2'b00, live[i]};
    end
    csr_conflict_d = (csr_cnt >= 3'd2);
  end

  // Next state. Once halted, live is all zero, so the enables, the retire
  // mask and the counter hold off automatically. The address and data
  // registers also stop updating.
  always_comb begin
    state_d = state_q;
    if ((state_q == StRun) && |(live & in_halt)) begin
      state_d = StHalted;
    end
    retired_d      = live;
    retire_count_d = retire_count_q + CNTBITS'(live_cnt);
    if (state_q == StRun) begin
      rf_waddr_d = in_wregno;
      rf_wdata_d = in_regval;
    end else begin
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StRun;
      rf_we_q        <= '0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      csr_we_q       <= 1'b0;
      csr_waddr_q    <= '0;
      csr_wdata_q    <= '0;
      csr_conflict_q <= 1'b0;
      retire_count_q <= '0;
      retired_q      <= '0;
    end else begin
      state_q        <= state_d;
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
      csr_we_q       <= csr_we_d;
      csr_waddr_q    <= csr_waddr_d;
      csr_wdata_q    <= csr_wdata_d;
      csr_conflict_q <= csr_conflict_d;
      retire_count_q <= retire_count_d;
      retired_q      <= retired_d;
    end
  end

  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign csr_we       = csr_we_q;
  assign csr_waddr    = csr_waddr_q;
  assign csr_wdata    = csr_wdata_q;
  assign csr_conflict = csr_conflict_q;
  assign retire_count = retire_count_q;
  assign retired      = retired_q;
  assign halted       = (state_q == StHalted);

`ifdef WB_TRACE_EN
  // Simulation-only view of the last value written to each register.
  logic [DBITS-1:0] last_wb_value [2**REGNOBITS];

  always @(negedge clk) begin
    for (int unsigned i = 0; i < LANES; i++) begin
      if (rf_we_q[i]) begin
        last_wb_value[rf_waddr_q[i*REGNOBITS +: REGNOBITS]] <= rf_wdata_q[i*DBITS +: DBITS];
      end
      if (retired_q[i]) begin
        $display("wb lane %0d x%0d = %h", i, rf_waddr_q[i*REGNOBITS +: REGNOBITS],
                 rf_wdata_q[i*DBITS +: DBITS]);
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_wb_commit_multi.sv
// Scoreboard bench for wb_commit_multi (two lanes). A second instance with a
// 4-bit counter shares the same inputs to exercise counter wrap.
module tb_wb_commit_multi;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  in_valid = '0, in_wr_reg = '0, in_wr_csr = '0, in_halt = '0;
  logic [9:0]  in_wregno = '0;
  logic [63:0] in_regval = '0, in_csrval = '0;
  logic [23:0] in_wcsrno = '0;

  logic [1:0]  rf_we, retired;
  logic [9:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        csr_we, csr_conflict, halted;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic [63:0] retire_count;

  logic [1:0]  d4_rf_we, d4_retired;
  logic [9:0]  d4_rf_waddr;
  logic [63:0] d4_rf_wdata;
  logic        d4_csr_we, d4_csr_conflict, d4_halted;
  logic [11:0] d4_csr_waddr;
  logic [31:0] d4_csr_wdata;
  logic [3:0]  d4_retire_count;

  wb_commit_multi #(.LANES(2), .DBITS(32), .REGNOBITS(5), .CSRNOBITS(12), .CNTBITS(64)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_wr_reg(in_wr_reg),
    .in_wregno(in_wregno), .in_regval(in_regval), .in_wr_csr(in_wr_csr),
    .in_wcsrno(in_wcsrno), .in_csrval(in_csrval), .in_halt(in_halt),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .csr_we(csr_we),
    .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_conflict(csr_conflict),
    .retire_count(retire_count), .retired(retired), .halted(halted)
  );

  wb_commit_multi #(.LANES(2), .DBITS(32), .REGNOBITS(5), .CSRNOBITS(12), .CNTBITS(4)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_wr_reg(in_wr_reg),
    .in_wregno(in_wregno), .in_regval(in_regval), .in_wr_csr(in_wr_csr),
    .in_wcsrno(in_wcsrno), .in_csrval(in_csrval), .in_halt(in_halt),
    .rf_we(d4_rf_we), .rf_waddr(d4_rf_waddr), .rf_wdata(d4_rf_wdata), .csr_we(d4_csr_we),
    .csr_waddr(d4_csr_waddr), .csr_wdata(d4_csr_wdata), .csr_conflict(d4_csr_conflict),
    .retire_count(d4_retire_count), .retired(d4_retired), .halted(d4_halted)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [1:0]  v, wr_reg, wr_csr, halt;
    logic [4:0]  r0, r1;
    logic [31:0] d0, d1;
    logic [11:0] c0, c1;
    logic [31:0] cv0, cv1;
  } vec_t;

  typedef struct {
    int          due;
    logic [1:0]  rf_we;
    logic        chk_data;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        conflict;
    logic [1:0]  retired;
    logic        halted;
    logic [63:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mkv(logic [1:0] v, logic [1:0] wr_reg, logic [4:0] r0,
                               logic [31:0] d0, logic [4:0] r1, logic [31:0] d1,
                               logic [1:0] wr_csr, logic [11:0] c0, logic [31:0] cv0,
                               logic [11:0] c1, logic [31:0] cv1, logic [1:0] halt);
    vec_t x;
    x.v = v; x.wr_reg = wr_reg; x.r0 = r0; x.d0 = d0; x.r1 = r1; x.d1 = d1;
    x.wr_csr = wr_csr; x.c0 = c0; x.cv0 = cv0; x.c1 = c1; x.cv1 = cv1; x.halt = halt;
    return x;
  endfunction

  function automatic exp_t mke(logic [1:0] we, logic cwe, logic [11:0] ca, logic [31:0] cd,
                               logic conf, logic [1:0] ret, logic h, logic [63:0] cnt,
                               logic [3:0] cnt4);
    exp_t e;
    e.due = 0; e.rf_we = we; e.chk_data = 1'b0; e.waddr = '0; e.wdata = '0;
    e.csr_we = cwe; e.csr_waddr = ca; e.csr_wdata = cd; e.conflict = conf;
    e.retired = ret; e.halted = h; e.cnt = cnt; e.cnt4 = cnt4;
    return e;
  endfunction

  task automatic put_inputs(input vec_t x);
    in_valid  = x.v;
    in_wr_reg = x.wr_reg;
    in_wregno = {x.r1, x.r0};
    in_regval = {x.d1, x.d0};
    in_wr_csr = x.wr_csr;
    in_wcsrno = {x.c1, x.c0};
    in_csrval = {x.cv1, x.cv0};
    in_halt   = x.halt;
  endtask

  // Drive one vector; its outputs are due after the next clock edge.
  task automatic send(input vec_t x, input exp_t e);
    @(posedge clk);
    #1;
    reset = 1'b0;
    put_inputs(x);
    e.due = cycle + 1;
    // Outside HALTED the address/data registers pass the inputs through.
    if (!e.halted) begin
      e.chk_data = 1'b1;
      e.waddr    = {x.r1, x.r0};
      e.wdata    = {x.d1, x.d0};
    end
    exp_q.push_back(e);
  endtask

  // Assert reset for one edge while presenting live-looking inputs.
  task automatic do_reset(input vec_t x);
    exp_t e;
    @(posedge clk);
    #1;
    reset = 1'b1;
    put_inputs(x);
    e = mke(2'b00, 1'b0, 12'h0, 32'h0, 1'b0, 2'b00, 1'b0, 64'd0, 4'd0);
    e.due = cycle + 1;
    e.chk_data = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cycle, act, exp);
    end
  endtask

  // Monitor: compares outputs away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && exp_q[0].due == cycle) begin
        e = exp_q.pop_front();
        chk("rf_we", {62'd0, rf_we}, {62'd0, e.rf_we});
        chk("retired", {62'd0, retired}, {62'd0, e.retired});
        chk("halted", {63'd0, halted}, {63'd0, e.halted});
        chk("retire_count", retire_count, e.cnt);
        chk("retire_count_w4", {60'd0, d4_retire_count}, {60'd0, e.cnt4});
        chk("csr_we", {63'd0, csr_we}, {63'd0, e.csr_we});
        chk("csr_conflict", {63'd0, csr_conflict}, {63'd0, e.conflict});
        if (e.csr_we) begin
          chk("csr_waddr", {52'd0, csr_waddr}, {52'd0, e.csr_waddr});
          chk("csr_wdata", {32'd0, csr_wdata}, {32'd0, e.csr_wdata});
        end
        if (e.chk_data) begin
          chk("rf_waddr", {54'd0, rf_waddr}, {54'd0, e.waddr});
          chk("rf_wdata", rf_wdata, e.wdata);
        end
      end
    end
  end

  initial begin
    vec_t idle;
    idle = mkv(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 12'h0, 32'h0, 12'h0, 32'h0, 2'b00);

    // Reset state
    do_reset(idle);
    // Two independent register writes
    send(mkv(2'b11, 2'b11, 5'd3, 32'h11, 5'd5, 32'h22, 2'b00, 12'h0, 32'h0, 12'h0, 32'h0, 2'b00),
         mke(2'b11, 1'b0, 12'h0, 32'h0, 1'b0, 2'b11, 1'b0, 64'd2, 4'd2));
    // Same register: only lane 1 survives
    send(mkv(2'b11, 2'b11, 5'd7, 32'hAA, 5'd7, 32'hBB, 2'b00, 12'h0, 32'h0, 12'h0, 32'h0, 2'b00),
         mke(2'b10, 1'b0, 12'h0, 32'h0, 1'b0, 2'b11, 1'b0, 64'd4, 4'd4));
    // x0 write suppressed but retired
    send(mkv(2'b01, 2'b01, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'h0, 2'b00, 12'h0, 32'h0, 12'h0, 32'h0, 2'b00),
         mke(2'b00, 1'b0, 12'h0, 32'h0, 1'b0, 2'b01, 1'b0, 64'd5, 4'd5));
    // CSR conflict, youngest wins
    send(mkv(2'b11, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 12'h300, 32'd1, 12'h305, 32'd2, 2'b00),
         mke(2'b00, 1'b1, 12'h305, 32'd2, 1'b1, 2'b11, 1'b0, 64'd7, 4'd7));
    // Single CSR write from lane 1 only
    send(mkv(2'b10, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b10, 12'h0, 32'h0, 12'h341, 32'd5, 2'b00),
         mke(2'b00, 1'b1, 12'h341, 32'd5, 1'b0, 2'b10, 1'b0, 64'd8, 4'd8));
    // Invalid younger lane does not kill an older write to the same register
    send(mkv(2'b01, 2'b11, 5'd7, 32'h77, 5'd7, 32'h99, 2'b00, 12'h0, 32'h0, 12'h0, 32'h0, 2'b00),
         mke(2'b01, 1'b0, 12'h0, 32'h0, 1'b0, 2'b01, 1'b0, 64'd9, 4'd9));

    // Mid-stream reset discards the inputs it sees
    do_reset(mkv(2'b11, 2'b11, 5'd1, 32'h1, 5'd2, 32'h2, 2'b11, 12'h1, 32'h1, 12'h2, 32'h2, 2'b00));

    // Counter wrap on the 4-bit instance
    for (int i = 0; i < 15; i++) begin
      send(mkv(2'b01, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 12'h0, 32'h0, 12'h0, 32'h0, 2'b00),
           mke(2'b00, 1'b0, 12'h0, 32'h0, 1'b0, 2'b01, 1'b0, 64'(i + 1), 4'(i + 1)));
    end
    send(mkv(2'b11, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 12'h0, 32'h0, 12'h0, 32'h0, 2'b00),
         mke(2'b00, 1'b0, 12'h0, 32'h0, 1'b0, 2'b11, 1'b0, 64'd17, 4'd1));

    // Halt on lane 0 squashes lane 1's write
    send(mkv(2'b11, 2'b10, 5'd0, 32'h0, 5'd4, 32'h44, 2'b00, 12'h0, 32'h0, 12'h0, 32'h0, 2'b01),
         mke(2'b00, 1'b0, 12'h0, 32'h0, 1'b0, 2'b01, 1'b1, 64'd18, 4'd2));
    // Halted: everything ignored, count frozen
    send(mkv(2'b11, 2'b11, 5'd1, 32'h5, 5'd2, 32'h6, 2'b11, 12'h300, 32'h1, 12'h301, 32'h2, 2'b00),
         mke(2'b00, 1'b0, 12'h0, 32'h0, 1'b0, 2'b00, 1'b1, 64'd18, 4'd2));
    send(mkv(2'b01, 2'b01, 5'd9, 32'h9, 5'd0, 32'h0, 2'b00, 12'h0, 32'h0, 12'h0, 32'h0, 2'b00),
         mke(2'b00, 1'b0, 12'h0, 32'h0, 1'b0, 2'b00, 1'b1, 64'd18, 4'd2));

    // Reset together with a halting lane: reset wins
    do_reset(mkv(2'b01, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 12'h0, 32'h0, 12'h0, 32'h0, 2'b01));
    send(idle, mke(2'b00, 1'b0, 12'h0, 32'h0, 1'b0, 2'b00, 1'b0, 64'd0, 4'd0));
    // Running again after reset: halt on lane 1 with lane 0 writing
    send(mkv(2'b11, 2'b01, 5'd9, 32'h99, 5'd0, 32'h0, 2'b00, 12'h0, 32'h0, 12'h0, 32'h0, 2'b10),
         mke(2'b01, 1'b0, 12'h0, 32'h0, 1'b0, 2'b11, 1'b1, 64'd2, 4'd2));

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
